// File: rtl/sdiv_32_32.sv
// Sequential 32-bit signed/unsigned divider.
// Operands arrive as 33-bit values (zero- or sign-extended), so one datapath
// covers both unsigned and signed division. The core is a restoring divider
// that runs one step per clock for 32 clocks. Signs are applied at the end.
// Divide by zero skips the iteration and returns all-ones with the dividend
// as the remainder.
module sdiv_32_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [32:0] ai,
  input  logic [32:0] bi,
  input  logic        req,
  output logic [31:0] q,
  output logic [31:0] rem,
  output logic        rdy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;     // dividend bits leave at the top, quotient bits enter at the bottom
  logic [31:0] prem_q, prem_d;   // partial remainder; always below the divisor magnitude
  logic [31:0] bmag_q, bmag_d;
  logic [31:0] alo_q, alo_d;     // raw low dividend bits, used as the divide-by-zero remainder
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        divz_q, divz_d;
  logic [31:0] q_q, q_d;
  logic [31:0] rem_q, rem_d;
  logic        rdy_q, rdy_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        qbit;
  logic        b_zero;

  // A magnitude is the low 32 bits of the operand, or of its negation when
  // the operand is negative. -2^31 gives 2^31, which still fits in 32 bits.
  assign a_mag  = ai[32] ? (~ai[31:0] + 32'd1) : ai[31:0];
  assign b_mag  = bi[32] ? (~bi[31:0] + 32'd1) : bi[31:0];
  assign b_zero = (bi == 33'd0);

  // The shift produces a 33-bit value. The compare is done at that width.
  // The difference is kept to 32 bits because it is always below the divisor.
  assign shifted = {prem_q, dvd_q[31]};
  assign qbit    = (shifted >= {1'b0, bmag_q});
  assign sub     = shifted[31:0] - bmag_q;

  // Register the state. Reset returns the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Choose the next state. req is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = b_zero ? FIX : CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Compute the next datapath and output values. Every register holds
  // its value unless the current state changes it.
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    prem_d = prem_q;
    bmag_d = bmag_q;
    alo_d  = alo_q;
    negq_d = negq_q;
    negr_d = negr_q;
    divz_d = divz_q;
    q_d    = q_q;
    rem_d  = rem_q;
    rdy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d  = 6'd0;
          dvd_d  = a_mag;
          prem_d = 32'd0;
          bmag_d = b_mag;
          alo_d  = ai[31:0];
          negq_d = ai[32] ^ bi[32];
          negr_d = ai[32];
          divz_d = b_zero;
        end
      end
      CALC: begin
        cnt_d  = cnt_q + 6'd1;
        prem_d = qbit ? sub : shifted[31:0];
        dvd_d  = {dvd_q[30:0], qbit};
      end
      FIX: begin
        rdy_d = 1'b1;
        if (divz_q) begin
          q_d   = 32'hFFFF_FFFF;
          rem_d = alo_q;
        end else begin
          q_d   = negq_q ? (~dvd_q + 32'd1) : dvd_q;
          rem_d = negr_q ? (~prem_q + 32'd1) : prem_q;
        end
      end
      default: ;
    endcase
  end

  // Register the datapath and outputs. Reset clears the counter and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 6'd0;
      dvd_q  <= 32'd0;
      prem_q <= 32'd0;
      bmag_q <= 32'd0;
      alo_q  <= 32'd0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      divz_q <= 1'b0;
      q_q    <= 32'd0;
      rem_q  <= 32'd0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
      bmag_q <= bmag_d;
      alo_q  <= alo_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      divz_q <= divz_d;
      q_q    <= q_d;
      rem_q  <= rem_d;
      rdy_q  <= rdy_d;
    end
  end

  assign q   = q_q;
  assign rem = rem_q;
  assign rdy = rdy_q;

endmodule

// File: tb/tb_sdiv_32_32.sv
// Directed testbench for sdiv_32_32. Expected values are worked out by hand.
module tb_sdiv_32_32;

  logic        clk;
  logic        rst_n;
  logic [32:0] ai;
  logic [32:0] bi;
  logic        req;
  logic [31:0] q;
  logic [31:0] rem;
  logic        rdy;

  int n_checks = 0;
  int n_fail   = 0;

  sdiv_32_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ai    (ai),
    .bi    (bi),
    .req   (req),
    .q     (q),
    .rem   (rem),
    .rdy   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation. The capture happens at edge 0.
  // rdy must rise only after edge lat, and q/rem are checked at that point.
  task automatic do_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int lat);
    ai  = a;
    bi  = b;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_rdy"}, {31'd0, rdy}, {31'd0, (k == lat)});
      if (k == lat) begin
        check({tag, "_q"}, q, eq);
        check({tag, "_rem"}, rem, er);
      end
    end
    $display("op %s: ai=%h bi=%h -> q=%h rem=%h", tag, a, b, q, rem);
  endtask

  initial begin
    rst_n = 1'b0;
    ai    = 33'd0;
    bi    = 33'd0;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", q, 32'd0);
    check("reset_rem", rem, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("u100_7",   33'd100,          33'd7,            32'd14,         32'd2,          33);
    do_op("n100_7",   -33'sd100,        33'd7,            32'hFFFF_FFF2,  32'hFFFF_FFFE,  33);
    do_op("100_n7",   33'd100,          -33'sd7,          32'hFFFF_FFF2,  32'd2,          33);
    do_op("max_1",    33'h0_FFFF_FFFF,  33'd1,            32'hFFFF_FFFF,  32'd0,          33);
    do_op("ovf",      33'h1_8000_0000,  -33'sd1,          32'h8000_0000,  32'd0,          33);
    do_op("big_3",    33'h0_FFFF_FFFF,  33'd3,            32'h5555_5555,  32'd0,          33);
    do_op("n7_n2",    -33'sd7,          -33'sd2,          32'd3,          32'hFFFF_FFFF,  33);
    do_op("dz_5",     33'd5,            33'd0,            32'hFFFF_FFFF,  32'd5,          1);
    do_op("dz_n5",    -33'sd5,          33'd0,            32'hFFFF_FFFF,  32'hFFFF_FFFB,  1);

    // Hold req high without a break. The operands change at edge 20, while
    // the first operation is still running. The second capture then happens
    // at edge 35 and uses the new operands.
    ai  = 33'd100;
    bi  = 33'd7;
    req = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 69; e++) begin
      @(posedge clk);
      #1;
      check("b2b_rdy", {31'd0, rdy}, {31'd0, (e == 33 || e == 68)});
      if (e == 19) begin
        ai = 33'd12;
        bi = 33'd5;
      end
      if (e == 33) begin
        check("b2b_q1", q, 32'd14);
        check("b2b_rem1", rem, 32'd2);
      end
      if (e == 68) begin
        check("b2b_q2", q, 32'd2);
        check("b2b_rem2", rem, 32'd2);
        req = 1'b0;
      end
    end
    $display("op b2b: 100/7 then 12/5 with req held -> q=%h rem=%h", q, rem);

    // Reset at edge 10 of an operation. The operation must be abandoned,
    // with no rdy afterwards, and q/rem must be cleared.
    ai  = 33'd50;
    bi  = 33'd3;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      check("abort_rdy", {31'd0, rdy}, 32'd0);
      if (e == 9) rst_n = 1'b0;
      if (e == 10) begin
        check("abort_q", q, 32'd0);
        check("abort_rem", rem, 32'd0);
        rst_n = 1'b1;
      end
    end
    check("abort_q_hold", q, 32'd0);
    check("abort_rem_hold", rem, 32'd0);
    $display("op abort: 50/3 reset at edge 10 -> q=%h rem=%h", q, rem);

    do_op("post_12_5", 33'd12, 33'd5, 32'd2, 32'd2, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: stop the run if the main sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
